// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single-ported main memory.
// Round-robin ties with a capped DMA burst lock; one access per cycle.
module mem_port_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_lock,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [15:0] dma_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [2:0] BURST_LIM = 3'(MAX_BURST);

    owner_t      last_owner;
    owner_t      last_owner_next;
    owner_t      rd_owner;
    logic [2:0]  burst_cnt;
    logic        rd_pending;
    logic        dma_wins;
    logic [15:0] cpu_rdata_q;
    logic [15:0] dma_rdata_q;

    // Grant decode: DMA wins a tie unless it owned last and its lock is spent.
    always_comb begin
        cpu_gnt  = 1'b0;
        dma_gnt  = 1'b0;
        dma_wins = (last_owner == OWN_CPU) ||
                   (dma_lock && (burst_cnt < BURST_LIM));
        if (!reset) begin
            if (cpu_req && dma_req) begin
                dma_gnt = dma_wins;
                cpu_gnt = !dma_wins;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    // Memory port mux; idle cycles park on the CPU inputs with no write.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        unique case (1'b1)
            dma_gnt: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we;
            end
            cpu_gnt: mem_we = cpu_we;
            default: ;
        endcase
    end

    // Next round-robin owner follows whoever was granted this cycle.
    always_comb begin
        last_owner_next = last_owner;
        if (cpu_gnt) begin
            last_owner_next = OWN_CPU;
        end else if (dma_gnt) begin
            last_owner_next = OWN_DMA;
        end
    end

    // Round-robin state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner <= OWN_CPU;
        end else begin
            last_owner <= last_owner_next;
        end
    end

    // Burst counter: runs on locked DMA grants, saturates, else clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= 3'd0;
        end else if (dma_gnt && dma_lock) begin
            if (burst_cnt != 3'd7) begin
                burst_cnt <= burst_cnt + 3'd1;
            end
        end else begin
            burst_cnt <= 3'd0;
        end
    end

    // Track which requester owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            rd_pending <= (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
            if (cpu_gnt || dma_gnt) begin
                rd_owner <= dma_gnt ? OWN_DMA : OWN_CPU;
            end
        end
    end

    // Capture returned data so each side's rdata holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (dma_rvalid) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid = !reset && rd_pending && (rd_owner == OWN_CPU);
    assign dma_rvalid = !reset && rd_pending && (rd_owner == OWN_DMA);
    assign cpu_rdata  = reset ? 16'h0000 :
                        (cpu_rvalid ? mem_rdata : cpu_rdata_q);
    assign dma_rdata  = reset ? 16'h0000 :
                        (dma_rvalid ? mem_rdata : dma_rdata_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        dma_req, dma_lock, dma_we;
    logic [15:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [15:0] dma_rdata;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata = 16'h0000;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          m_last;
    int          m_burst;
    bit          m_rv;
    int          m_rown;
    logic [15:0] m_rdat, m_cheld, m_dheld;

    // model expectations for the current cycle
    int          e_win;
    logic        e_cg, e_dg, e_we, e_crv, e_drv;
    logic [15:0] e_addr, e_wd, e_crd, e_drd;

    mem_port_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // memory returns a known function of the address one cycle later
    always @(posedge clk) mem_rdata <= mem_addr ^ 16'hBEFF;

    function automatic logic [68:0] obs_vec();
        return {cpu_gnt, dma_gnt, mem_we, mem_addr, mem_wdata,
                cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata};
    endfunction

    function automatic logic [68:0] exp_vec();
        return {e_cg, e_dg, e_we, e_addr, e_wd,
                e_crv, e_drv, e_crd, e_drd};
    endfunction

    task automatic set_in(input logic cr, input logic cw,
                          input logic [15:0] ca, input logic [15:0] cd,
                          input logic dr, input logic dl, input logic dw,
                          input logic [15:0] da, input logic [15:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_lock = dl; dma_we = dw;
        dma_addr = da; dma_wdata = dd;
    endtask

    // expected outputs for the inputs currently applied
    task automatic model_eval();
        e_win = 0;
        if (reset) begin
            e_crv = 0; e_drv = 0; e_crd = 0; e_drd = 0;
        end else begin
            if (cpu_req && dma_req) begin
                if (m_last == 0) e_win = 2;
                else if (dma_lock && m_burst < MAXB) e_win = 2;
                else e_win = 1;
            end else if (cpu_req) e_win = 1;
            else if (dma_req) e_win = 2;
            e_crv = m_rv && m_rown == 1;
            e_drv = m_rv && m_rown == 2;
            e_crd = e_crv ? m_rdat : m_cheld;
            e_drd = e_drv ? m_rdat : m_dheld;
        end
        e_cg   = (e_win == 1);
        e_dg   = (e_win == 2);
        e_addr = e_dg ? dma_addr : cpu_addr;
        e_wd   = e_dg ? dma_wdata : cpu_wdata;
        e_we   = e_dg ? dma_we : (e_cg ? cpu_we : 1'b0);
    endtask

    // advance the model across the coming clock edge
    task automatic model_commit();
        if (reset) begin
            m_last = 0; m_burst = 0; m_rv = 0; m_rown = 0;
            m_rdat = 0; m_cheld = 0; m_dheld = 0;
        end else begin
            if (e_crv) m_cheld = m_rdat;
            if (e_drv) m_dheld = m_rdat;
            if (e_win != 0) m_last = (e_win == 2) ? 1 : 0;
            if (e_win == 2 && dma_lock)
                m_burst = (m_burst < 7) ? m_burst + 1 : 7;
            else
                m_burst = 0;
            m_rv   = (e_win != 0) && !e_we;
            m_rown = e_win;
            m_rdat = e_addr ^ 16'hBEFF;
        end
    endtask

    task automatic next_cycle();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_eval();
        @(negedge clk);
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        set_in(1, 0, 16'h0001, 0, 1, 1, 0, 16'h0002, 0);
        model_eval();
        @(negedge clk);
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid,
             cpu_rdata, dma_rdata, mem_we} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got g=%b%b rv=%b%b rd=%h/%h we=%b want all 0",
                     cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid,
                     cpu_rdata, dma_rdata, mem_we);
        end
        next_cycle();
        reset = 0;
        // requests held across reset release: first tie goes to DMA
        model_eval();
        @(negedge clk);
        vectors++;
        if ({cpu_gnt, dma_gnt} !== 2'b01 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL post_reset_tie: got %h want %h", obs_vec(), exp_vec());
        end
        next_cycle();
        apply_reset();
    endtask

    task automatic test_cpu_read();
        set_in(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
        model_eval();
        @(negedge clk);
        vectors++;
        if (cpu_gnt !== 1 || dma_gnt !== 0 || mem_addr !== 16'h0010 ||
            mem_we !== 0) begin
            miscompares++;
            $display("FAIL cpu_read_gnt: got g=%b%b a=%h we=%b want 10 0010 0",
                     cpu_gnt, dma_gnt, mem_addr, mem_we);
        end
        next_cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_eval();
        @(negedge clk);
        vectors++;
        if (cpu_rvalid !== 1 || cpu_rdata !== 16'hBEEF ||
            dma_rvalid !== 0) begin
            miscompares++;
            $display("FAIL cpu_read_data: got rv=%b d=%h drv=%b want 1 beef 0",
                     cpu_rvalid, cpu_rdata, dma_rvalid);
        end
        next_cycle();
        model_eval();
        @(negedge clk);
        vectors++;
        if (cpu_rvalid !== 0 || cpu_rdata !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL cpu_read_hold: got rv=%b d=%h want 0 beef",
                     cpu_rvalid, cpu_rdata);
        end
        next_cycle();
    endtask

    task automatic test_tie();
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 16'h0300 + 16'(i), 0, 1, 0, 0, 16'h0400 + 16'(i), 0);
            model_eval();
            @(negedge clk);
            vectors++;
            if ({cpu_gnt, dma_gnt} !== want[i] || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL tie_c%0d: got g=%b%b %h want g=%b %h", i,
                         cpu_gnt, dma_gnt, obs_vec(), want[i], exp_vec());
            end
            next_cycle();
        end
    endtask

    task automatic test_burst();
        logic [1:0] want [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 16'h0500, 0, 1, 1, 0, 16'h0600 + 16'(i), 0);
            model_eval();
            @(negedge clk);
            vectors++;
            if ({cpu_gnt, dma_gnt} !== want[i] || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL burst_c%0d: got g=%b%b %h want g=%b %h", i,
                         cpu_gnt, dma_gnt, obs_vec(), want[i], exp_vec());
            end
            next_cycle();
        end
    endtask

    task automatic test_writes();
        apply_reset();
        set_in(1, 1, 16'h0100, 16'h1234, 1, 0, 1, 16'h0200, 16'h5678);
        model_eval();
        @(negedge clk);
        vectors++;
        if ({dma_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata} !==
            {3'b101, 16'h0200, 16'h5678}) begin
            miscompares++;
            $display("FAIL wr_first: got g=%b%b we=%b %h/%h want dma 0200/5678",
                     cpu_gnt, dma_gnt, mem_we, mem_addr, mem_wdata);
        end
        next_cycle();
        dma_req = 0;
        model_eval();
        @(negedge clk);
        vectors++;
        if ({cpu_gnt, dma_gnt, mem_we, mem_addr, mem_wdata} !==
            {3'b101, 16'h0100, 16'h1234} || dma_rvalid !== 0) begin
            miscompares++;
            $display("FAIL wr_second: got g=%b%b we=%b %h/%h drv=%b want cpu 0100/1234",
                     cpu_gnt, dma_gnt, mem_we, mem_addr, mem_wdata, dma_rvalid);
        end
        next_cycle();
        cpu_req = 0;
        model_eval();
        @(negedge clk);
        vectors++;
        if (cpu_rvalid !== 0 || dma_rvalid !== 0 || mem_we !== 0) begin
            miscompares++;
            $display("FAIL wr_no_rvalid: got rv=%b%b we=%b want 000",
                     cpu_rvalid, dma_rvalid, mem_we);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_in(0, 0, 0, 0, 1, 0, 0, 16'h0042, 0);
        model_eval();
        @(negedge clk);
        vectors++;
        if (dma_gnt !== 1 || mem_addr !== 16'h0042) begin
            miscompares++;
            $display("FAIL rmr_gnt: got g=%b a=%h want 1 0042", dma_gnt, mem_addr);
        end
        next_cycle();
        reset = 1;
        dma_req = 0;
        model_eval();
        @(negedge clk);
        vectors++;
        if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we,
             cpu_rdata, dma_rdata} !== 37'd0) begin
            miscompares++;
            $display("FAIL rmr_suppress: got g=%b%b rv=%b%b we=%b rd=%h/%h want 0",
                     cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we,
                     cpu_rdata, dma_rdata);
        end
        next_cycle();
        reset = 0;
        model_eval();
        @(negedge clk);
        vectors++;
        if (dma_rvalid !== 0 || obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL rmr_after: got %h want %h", obs_vec(), exp_vec());
        end
        next_cycle();
    endtask

    task automatic test_dropped();
        apply_reset();
        set_in(0, 0, 0, 0, 1, 1, 0, 16'h0700, 0);
        model_eval();
        @(negedge clk);
        next_cycle();
        set_in(1, 1, 16'hDEAD, 16'hFACE, 1, 1, 0, 16'h0701, 0);
        model_eval();
        @(negedge clk);
        vectors++;
        if (cpu_gnt !== 0 || dma_gnt !== 1 || mem_we !== 0) begin
            miscompares++;
            $display("FAIL drop_pulse: got g=%b%b we=%b want 01 0",
                     cpu_gnt, dma_gnt, mem_we);
        end
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, (i == 0), 1, 0, 16'h0702, 0);
            model_eval();
            @(negedge clk);
            vectors++;
            if (cpu_gnt !== 0 || cpu_rvalid !== 0 || mem_we !== 0 ||
                obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL drop_after_c%0d: got %h want %h",
                         i, obs_vec(), exp_vec());
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        bit          cp, dp;
        logic        cw, dl, dw;
        logic [15:0] ca, cd, da, dd;
        cp = 0; dp = 0;
        cw = 0; dl = 0; dw = 0; ca = 0; cd = 0; da = 0; dd = 0;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (!cp && $urandom_range(3) != 0) begin
                cp = 1; cw = 1'($urandom); ca = 16'($urandom); cd = 16'($urandom);
            end
            if (!dp && $urandom_range(3) != 0) begin
                dp = 1; dl = ($urandom_range(3) != 0); dw = 1'($urandom);
                da = 16'($urandom); dd = 16'($urandom);
            end
            reset = ($urandom_range(59) == 0);
            set_in(cp, cw, ca, cd, dp, dl, dw, da, dd);
            model_eval();
            @(negedge clk);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rand_c%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (e_cg) cp = 0;
            if (e_dg) dp = 0;
            next_cycle();
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_last = 0; m_burst = 0; m_rv = 0; m_rown = 0;
        m_rdat = 0; m_cheld = 0; m_dheld = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_cpu_read();
        test_tie();
        test_burst();
        test_writes();
        test_reset_mid_read();
        test_dropped();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 The clock and reset ports SHALL be as follows:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-003 The CPU requester ports SHALL be as follows:
- cpu_req  in  1  CPU data access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU data address.
- cpu_wdata  in  16  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  16  CPU read data.
REQ-004 The DMA requester ports SHALL be as follows:
- dma_req  in  1  DMA (draw-list fetch) request.
- dma_lock  in  1  request to hold grant for a burst.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  16  DMA data address.
- dma_wdata  in  16  DMA write data.
- dma_gnt  out  1  DMA access issued this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  16  DMA read data.
REQ-005 The memory-side ports SHALL be as follows:
- mem_addr  out  16  main memory data-port address.
- mem_wdata  out  16  main memory write data.
- mem_we  out  1  main memory write enable.
- mem_rdata  in  16  main memory read data; valid one cycle after the address is presented.
REQ-006 Parameter MAX_BURST SHALL have default 4 and SHALL give the maximum number of consecutive locked DMA grants (range 1..7).

Function
REQ-007 Grants SHALL be combinational from the current cycle's cpu_req/dma_req and the registered arbitration state, and SHALL never be asserted together.
REQ-008 Grant rules SHALL be as follows:
- Only one requester active: grant it.
- Neither active: no grant.
- Both active: grant per REQ-009/REQ-010.
REQ-009 Round-robin: a registered last_owner bit (0 = CPU, 1 = DMA) SHALL update on every granted cycle. On a tie, the requester that is not last_owner SHALL win.
REQ-010 Burst lock:
- A 3-bit burst_cnt SHALL count consecutive DMA grants while dma_lock=1.
- On a tie with last_owner=DMA, dma_lock=1 and burst_cnt < MAX_BURST, DMA SHALL win.
- Once burst_cnt = MAX_BURST, CPU SHALL win the next tie.
- burst_cnt SHALL clear on any CPU grant, any idle cycle, or any DMA grant with dma_lock=0.
REQ-011 The granted requester's addr/wdata/we SHALL drive mem_addr/mem_wdata/mem_we in the grant cycle.
REQ-012 With no grant, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL hold the CPU inputs.
REQ-013 A granted read (we=0) SHALL produce exactly one rvalid pulse to its owner in the following cycle, with rdata = mem_rdata.
REQ-014 A granted write SHALL produce no rvalid.
REQ-015 A registered 1-bit rd_owner and rd_pending SHALL route read data. The non-owner rdata SHALL hold its last captured value, and its rvalid SHALL be 0.
REQ-016 Back-to-back grants SHALL be legal every cycle, giving full throughput of 1 access per cycle with no bubbles.
REQ-017 A requester SHALL hold req and its qualifiers stable until gnt. A deasserted req without gnt SHALL be dropped with no side effects.
REQ-018 Two simultaneous writes SHALL be serialised: the loser's write SHALL be issued on a later grant and never merged.

Reset
REQ-019 Reset SHALL force the following state:
- last_owner = 0 (CPU), so the first tie goes to DMA.
- burst_cnt = 0, rd_pending = 0.
- cpu_rvalid = dma_rvalid = 0, cpu_rdata = dma_rdata = 0.
- No grant is issued in the reset cycle.
REQ-020 Reset asserted the cycle after a granted read SHALL suppress that read's rvalid.
REQ-021 Requests present when reset deasserts SHALL be arbitrated normally in the next cycle.

Verification
REQ-022 Bench scenario, CPU-only read: cpu_req=1, cpu_we=0, cpu_addr=0x0010, mem returns 0xBEEF -> cpu_gnt=1 in cycle N; cpu_rvalid=1 with cpu_rdata=0xBEEF in N+1; dma_rvalid stays 0.
REQ-023 Bench scenario, tie after reset: both req for 4 cycles, dma_lock=0 -> grants alternate DMA, CPU, DMA, CPU.
REQ-024 Bench scenario, burst cap: both req, dma_lock=1, MAX_BURST=4 -> 4 DMA grants, then 1 CPU grant, then DMA resumes.
REQ-025 Bench scenario, simultaneous writes: both we=1, cpu_addr=0x0100/0x1234, dma_addr=0x0200/0x5678 -> one mem write per cycle over 2 cycles, in round-robin order; no rvalid.
REQ-026 Bench scenario, reset mid-read: DMA read granted in cycle N, reset=1 in N+1 -> dma_rvalid=0 in N+1; all outputs at reset values.
REQ-027 Bench scenario, dropped request: cpu_req pulses for 1 cycle while DMA holds the lock -> no cpu_gnt, no cpu_rvalid, and no memory write from the CPU side.
